game_rom_loader: RTL and testbench
==================================

// Module: game_rom_loader
// PURPOSE
//  Receiving end of the SoC game_rom_conduit: captures PRG/CHR byte-write strobes issued by the Nios
//  cartridge loader, buffers them, and commits them to the NES-side PRG/CHR ROM memories.
//  Holds the NES core in reset while a cartridge is loading; releases it once loading goes idle.
// PARAMETERS
//  FIFO_DEPTH    8      write-queue entries, power of two >= 2
//  PRG_AW        15     PRG address width (32 KiB)
//  CHR_AW        13     CHR address width (8 KiB)
//  IDLE_CYCLES   4096   quiet cycles after last accepted strobe before load is declared done
// PORTS
//  clk            in   1      system clock (same domain as SoC conduit)
//  reset          in   1      asynchronous, active-high
//  rom_data       in   8      conduit byte
//  rom_addr       in   16     conduit byte address
//  prg_rom_write  in   1      conduit PRG strobe (level from PIO, may stay high many cycles)
//  chr_rom_write  in   1      conduit CHR strobe (same)
//  mem_we         out  1      memory write request
//  mem_sel        out  1      0 = PRG, 1 = CHR
//  mem_addr       out  16     zero-extended PRG_AW/CHR_AW address
//  mem_wdata      out  8      byte
//  mem_ready      in   1      write accepted when mem_we && mem_ready
//  nes_reset      out  1      high = hold NES core in reset
//  load_done      out  1      high in READY
//  byte_count     out  17     bytes committed to memory this load
//  err_flags      out  3      sticky: [0] FIFO overflow, [1] address out of range, [2] PRG+CHR collision
//  checksum       out  16     see CONFIGURATION
// BEHAVIOUR
//  - Reset: state EMPTY, FIFO empty, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, nes_reset=1,
//    load_done=0, byte_count=0, err_flags=0, checksum=0. Reset mid-load discards the queue.
//  - Strobes are rising-edge detected (1 registered delay); one accepted write per rising edge.
//  - Both rising same cycle: PRG accepted, CHR dropped, err_flags[2] set.
//  - rom_addr >= 2**PRG_AW (PRG) or >= 2**CHR_AW (CHR): dropped, err_flags[1] set; timer still reloads.
//  - FIFO full at accept: entry dropped, err_flags[0] set. Simultaneous push+pop on full FIFO is legal (no drop).
//  - Drain: head entry driven on mem_* with mem_we=1 while FIFO non-empty; pop and byte_count++ on mem_ready.
//    mem_* held stable while mem_we && !mem_ready. Minimum latency edge->mem_we = 2 cycles.
//  - FSM: EMPTY --accepted edge--> LOADING; LOADING: each edge reloads idle timer to IDLE_CYCLES;
//    LOADING --timer==0 && FIFO empty && !mem_we--> READY; READY --accepted edge--> LOADING.
//  - Entering LOADING from EMPTY/READY clears byte_count and checksum (err_flags stay sticky until reset).
//  - nes_reset = (state != READY), registered; load_done = (state == READY).
//  - byte_count saturates at 2**17-1.
// CONFIGURATION
//  - LOAD_CHECKSUM_EN defined: checksum = 16-bit wrapping sum of every byte committed (on mem_we&&mem_ready)
//    since entering LOADING; frozen in READY.
//  - Not defined: checksum tied to 16'h0000, no adder logic.
// STRUCTURE
//  - rom_load_pkg: state enum {EMPTY, LOADING, READY}, MEM_SEL_PRG/MEM_SEL_CHR, err bit indices, entry struct
//    {sel, addr[15:0], data[7:0]}.
//  - Sub-module: rom_load_fifo (synchronous FIFO, FIFO_DEPTH x 25 bits, full/empty, show-ahead head).
//  - Top: edge detect, range check, idle timer, FSM, counters.
// TESTING
//  1. PRG strobe held 20 cycles, addr 16'h0010, data 8'hA5, mem_ready=1 -> exactly one write PRG/0x0010/0xA5,
//     byte_count=1, nes_reset=1 until IDLE_CYCLES elapse, then load_done=1, nes_reset=0.
//  2. 32 PRG + 8 CHR writes with mem_ready=0 for 50 cycles -> first 8 queued, remaining dropped, err_flags[0]=1;
//     release mem_ready -> 8 writes in order, byte_count=8.
//  3. Both strobes rise same cycle -> single PRG write, err_flags[2]=1.
//  4. CHR write addr 16'h2000 -> no mem_we, err_flags[1]=1; state still LOADING.
//  5. In READY, new PRG edge -> nes_reset=1 next cycle, byte_count=0, LOADING; reset asserted mid-drain -> all
//     outputs return to reset values asynchronously.
//  6. LOAD_CHECKSUM_EN: bytes 0xFF,0x02 -> checksum 16'h0101; without macro checksum stays 0.

Source files
------------

// File: rtl/rom_load_pkg.sv
// rom_load_pkg
//   Shared types and constants for the cartridge ROM loader:
//   - load_state_t : loader FSM states (EMPTY, LOADING, READY)
//   - MEM_SEL_*    : memory select encodings (PRG / CHR)
//   - ERR_*        : bit positions inside err_flags
//   - rom_entry_t  : one queued byte write {sel, addr, data}, 25 bits
//   - addr_in_range: true when a byte address fits in an aw-bit memory
package rom_load_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } load_state_t;

    localparam logic MEM_SEL_PRG = 1'b0;
    localparam logic MEM_SEL_CHR = 1'b1;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_RANGE     = 1;
    localparam int ERR_COLLISION = 2;

    typedef struct packed {
        logic        sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } rom_entry_t;

    function automatic logic addr_in_range(input logic [15:0] addr, input int aw);
        return (32'(addr) >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/rom_load_fifo.sv
// rom_load_fifo
//   Synchronous write queue, DEPTH x rom_entry_t, with a show-ahead head.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset (empties the queue)
//     push, push_entry enqueue request and data (ignored when full unless popping)
//     pop              dequeue request (ignored when empty)
//     head             current head entry (valid while !empty)
//     full, empty      occupancy flags
module rom_load_fifo
    import rom_load_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  rom_entry_t push_entry,
    input  logic       pop,
    output rom_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    rom_entry_t storage [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = storage[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/game_rom_loader.sv
// game_rom_loader
//   Receives PRG/CHR byte-write strobes from the SoC cartridge loader, queues
//   them and commits them to the NES-side ROM memories. Holds the NES core in
//   reset until loading has been quiet for IDLE_CYCLES cycles.
//   Optional feature macro: LOAD_CHECKSUM_EN (16-bit sum of committed bytes;
//   when undefined the checksum output is tied to zero).
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     rom_data, rom_addr         conduit byte and byte address
//     prg_rom_write, chr_rom_write  level strobes, rising edge = one write
//     mem_we/sel/addr/wdata      write request to ROM memories (sel 0=PRG 1=CHR)
//     mem_ready                  write accepted when mem_we && mem_ready
//     nes_reset, load_done       NES core reset hold / load complete
//     byte_count                 bytes committed this load (saturating)
//     err_flags                  sticky [0] overflow, [1] range, [2] collision
//     checksum                   see LOAD_CHECKSUM_EN
module game_rom_loader
    import rom_load_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int PRG_AW      = 15,
    parameter int CHR_AW      = 13,
    parameter int IDLE_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rom_data,
    input  logic [15:0] rom_addr,
    input  logic        prg_rom_write,
    input  logic        chr_rom_write,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    output logic        nes_reset,
    output logic        load_done,
    output logic [16:0] byte_count,
    output logic [2:0]  err_flags,
    output logic [15:0] checksum
);

    localparam int TW = $clog2(IDLE_CYCLES + 1);

    load_state_t state_reg;
    logic [TW-1:0] timer_reg;
    logic          prg_q_reg, chr_q_reg;
    logic          pend_valid_reg;
    rom_entry_t    pend_entry_reg;
    logic          nes_reset_reg, load_done_reg;
    logic [16:0]   byte_count_reg;
    logic [2:0]    err_flags_reg;

    logic       prg_rise, chr_rise, edge_any, collision, in_range, accept;
    logic       edge_sel, overflow, commit;
    logic [2:0] err_set;
    rom_entry_t capture_entry, head;
    logic       fifo_full, fifo_empty;

    assign prg_rise = prg_rom_write & ~prg_q_reg;
    assign chr_rise = chr_rom_write & ~chr_q_reg;

    always_comb begin
        collision = prg_rise & chr_rise;
        edge_any  = prg_rise | chr_rise;
        // PRG wins a simultaneous edge; the CHR write is discarded.
        edge_sel  = prg_rise ? MEM_SEL_PRG : MEM_SEL_CHR;
        in_range  = (edge_sel == MEM_SEL_PRG) ? addr_in_range(rom_addr, PRG_AW)
                                              : addr_in_range(rom_addr, CHR_AW);
        accept    = edge_any & in_range;
        capture_entry = '{sel: edge_sel, addr: rom_addr, data: rom_data};
        overflow  = pend_valid_reg & fifo_full & ~commit;
        err_set                = '0;
        err_set[ERR_OVERFLOW]  = overflow;
        err_set[ERR_RANGE]     = edge_any & ~in_range;
        err_set[ERR_COLLISION] = collision;
    end

    rom_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (pend_valid_reg),
        .push_entry (pend_entry_reg),
        .pop        (commit),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Head is gated so the bus reads zero whenever nothing is pending.
    assign mem_we     = ~fifo_empty;
    assign mem_sel    = fifo_empty ? MEM_SEL_PRG : head.sel;
    assign mem_addr   = fifo_empty ? 16'h0000 : head.addr;
    assign mem_wdata  = fifo_empty ? 8'h00 : head.data;
    assign commit     = mem_we & mem_ready;
    assign nes_reset  = nes_reset_reg;
    assign load_done  = load_done_reg;
    assign byte_count = byte_count_reg;
    assign err_flags  = err_flags_reg;

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] checksum_reg;
    assign checksum = checksum_reg;
`else
    assign checksum = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= EMPTY;
            timer_reg      <= '0;
            prg_q_reg      <= 1'b0;
            chr_q_reg      <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_entry_reg <= '0;
            nes_reset_reg  <= 1'b1;
            load_done_reg  <= 1'b0;
            byte_count_reg <= '0;
            err_flags_reg  <= '0;
`ifdef LOAD_CHECKSUM_EN
            checksum_reg   <= '0;
`endif
        end else begin
            prg_q_reg      <= prg_rom_write;
            chr_q_reg      <= chr_rom_write;
            pend_valid_reg <= accept;
            pend_entry_reg <= capture_entry;
            err_flags_reg  <= err_flags_reg | err_set;
            if (commit && byte_count_reg != '1) begin
                byte_count_reg <= byte_count_reg + 1'b1;
            end
`ifdef LOAD_CHECKSUM_EN
            if (commit) begin
                checksum_reg <= checksum_reg + {8'h00, mem_wdata};
            end
`endif
            case (state_reg)
                EMPTY, READY: begin
                    if (accept) begin
                        // A new load starts: counters restart, error flags persist.
                        state_reg      <= LOADING;
                        timer_reg      <= TW'(IDLE_CYCLES);
                        byte_count_reg <= '0;
                        nes_reset_reg  <= 1'b1;
                        load_done_reg  <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
                        checksum_reg   <= '0;
`endif
                    end
                end
                LOADING: begin
                    // Any strobe edge, even a dropped one, proves the loader is alive.
                    if (edge_any) begin
                        timer_reg <= TW'(IDLE_CYCLES);
                    end else if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 1'b1;
                    end else if (!pend_valid_reg && fifo_empty) begin
                        state_reg     <= READY;
                        nes_reset_reg <= 1'b0;
                        load_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    nes_reset_reg <= 1'b1;
                    load_done_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_rom_loader.sv
// tb_game_rom_loader
//   Randomized, scoreboard-checked bench for game_rom_loader. Every write the
//   reference model expects to reach memory is queued when the strobe is
//   issued; a monitor pops and compares on each mem_we && mem_ready.
module tb_game_rom_loader;

    localparam int FIFO_DEPTH  = 8;
    localparam int PRG_AW      = 15;
    localparam int CHR_AW      = 13;
    localparam int IDLE_CYCLES = 64;
`ifdef LOAD_CHECKSUM_EN
    localparam bit CK_ON = 1'b1;
    localparam logic [15:0] CK_FF02 = 16'h0101;
`else
    localparam bit CK_ON = 1'b0;
    localparam logic [15:0] CK_FF02 = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rom_data = 8'h00;
    logic [15:0] rom_addr = 16'h0000;
    logic        prg_rom_write = 1'b0;
    logic        chr_rom_write = 1'b0;
    logic        mem_we, mem_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b1;
    logic        nes_reset, load_done;
    logic [16:0] byte_count;
    logic [2:0]  err_flags;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [24:0] exp_q[$];
    logic [2:0]  exp_err = 3'b000;
    int          model_count = 0;
    logic [15:0] model_sum = 16'h0000;
    bit          model_idle = 1'b1;
    bit          rand_ready = 1'b0;
    logic        ready_level = 1'b1;

    game_rom_loader #(
        .FIFO_DEPTH(FIFO_DEPTH), .PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .rom_data(rom_data), .rom_addr(rom_addr),
        .prg_rom_write(prg_rom_write), .chr_rom_write(chr_rom_write),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .nes_reset(nes_reset), .load_done(load_done),
        .byte_count(byte_count), .err_flags(err_flags), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on commit, bus stability while stalled.
    logic [24:0] prev_bus = '0;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_we && prev_stall)
                check("hold_stable", 32'({mem_sel, mem_addr, mem_wdata}), 32'(prev_bus));
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got sel=%0d addr=0x%h data=0x%h, none expected",
                             mem_sel, mem_addr, mem_wdata);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("write", 32'({mem_sel, mem_addr, mem_wdata}), 32'(e));
                    $display("commit %s addr=0x%h data=0x%h", mem_sel ? "CHR" : "PRG", mem_addr, mem_wdata);
                end
            end
            prev_stall = mem_we && !mem_ready;
            prev_bus   = {mem_sel, mem_addr, mem_wdata};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of one accepted-or-dropped strobe edge (sel: 0 PRG, 1 CHR).
    task automatic model_edge(input bit sel, input logic [15:0] addr, input logic [7:0] data,
                              input bit stall);
        bit ok;
        ok = sel ? (int'(addr) < (1 << CHR_AW)) : (int'(addr) < (1 << PRG_AW));
        if (!ok) begin
            exp_err[1] = 1'b1;
        end else begin
            if (model_idle) begin
                model_count = 0;
                model_sum   = 16'h0000;
                model_idle  = 1'b0;
            end
            if (stall && exp_q.size() >= FIFO_DEPTH) begin
                exp_err[0] = 1'b1;
            end else begin
                exp_q.push_back({sel, addr, data});
                model_count++;
                model_sum = model_sum + {8'h00, data};
            end
        end
    endtask

    task automatic issue(input bit sel, input logic [15:0] addr, input logic [7:0] data,
                         input int hold, input bit stall);
        model_edge(sel, addr, data, stall);
        step();
        rom_addr = addr;
        rom_data = data;
        if (sel) chr_rom_write = 1'b1;
        else     prg_rom_write = 1'b1;
        repeat (hold) step();
        prg_rom_write = 1'b0;
        chr_rom_write = 1'b0;
    endtask

    task automatic issue_both(input logic [15:0] addr, input logic [7:0] data);
        exp_err[2] = 1'b1;
        model_edge(1'b0, addr, data, 1'b0);
        step();
        rom_addr = addr;
        rom_data = data;
        prg_rom_write = 1'b1;
        chr_rom_write = 1'b1;
        step();
        prg_rom_write = 1'b0;
        chr_rom_write = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_we) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_done && n < IDLE_CYCLES * 3 + 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(load_done), 32'd1);
        model_idle = 1'b1;
    endtask

    function automatic logic [15:0] exp_ck();
        return CK_ON ? model_sum : 16'h0000;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          any_we;
        bit          sel;
        logic [15:0] addr;
        int          n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_bus", 32'({mem_sel, mem_addr, mem_wdata}), 32'd0);
        check("rst_nes_reset", 32'(nes_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_err_flags", 32'(err_flags), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        step();
        reset = 1'b0;

        // 1: long PRG strobe -> one write, 2-cycle latency, then READY
        model_edge(1'b0, 16'h0010, 8'hA5, 1'b0);
        step();
        rom_addr = 16'h0010;
        rom_data = 8'hA5;
        prg_rom_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t1_latency_1", 32'(mem_we), 32'd0);
        check("t1_nes_reset", 32'(nes_reset), 32'd1);
        @(negedge clk);
        check("t1_latency_2", 32'(mem_we), 32'd1);
        repeat (18) step();
        prg_rom_write = 1'b0;
        wait_drain();
        check("t1_byte_count", 32'(byte_count), 32'd1);
        repeat (IDLE_CYCLES - 30) @(negedge clk);
        check("t1_not_ready_early", 32'(load_done), 32'd0);
        check("t1_nes_reset_held", 32'(nes_reset), 32'd1);
        wait_ready();
        check("t1_nes_reset_rel", 32'(nes_reset), 32'd0);
        check("t1_checksum", 32'(checksum), 32'(exp_ck()));

        // 2: stall memory, flood 32 PRG + 8 CHR writes, only 8 survive
        ready_level = 1'b0;
        step();
        step();
        for (int i = 0; i < 40; i++)
            issue(i >= 32, 16'($urandom_range(0, (i >= 32) ? 16'h1FFF : 16'h7FFF)),
                  8'($urandom_range(0, 255)), 1, 1'b1);
        repeat (10) step();
        check("t2_err_overflow", 32'(err_flags), 32'(exp_err));
        check("t2_stalled_we", 32'(mem_we), 32'd1);
        ready_level = 1'b1;
        wait_drain();
        check("t2_byte_count", 32'(byte_count), 32'(model_count));
        check("t2_checksum", 32'(checksum), 32'(exp_ck()));
        wait_ready();

        // 3: simultaneous PRG+CHR edges -> single PRG write
        issue_both(16'h0123, 8'h3C);
        wait_drain();
        check("t3_err_collision", 32'(err_flags), 32'(exp_err));

        // 4: CHR out of range -> no write, range flag, still loading
        issue(1'b1, 16'h2000, 8'h77, 1, 1'b0);
        any_we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_we |= mem_we;
        end
        check("t4_no_mem_we", 32'(any_we), 32'd0);
        check("t4_err_range", 32'(err_flags), 32'(exp_err));
        check("t4_still_loading", 32'(load_done), 32'd0);
        issue(1'b1, 16'h1FFF, 8'h11, 1, 1'b0);
        issue(1'b0, 16'h7FFF, 8'h22, 1, 1'b0);
        issue(1'b0, 16'h8000, 8'h33, 1, 1'b0);
        wait_drain();
        check("t4_boundary_err", 32'(err_flags), 32'(exp_err));

        // Random traffic with random mem_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (exp_q.size() >= 4 && n < 200) begin
                step();
                n++;
            end
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                addr = sel ? 16'($urandom_range(16'h2000, 16'hFFFF)) : 16'($urandom_range(16'h8000, 16'hFFFF));
            else
                addr = sel ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom_range(0, 16'h7FFF));
            if ($urandom_range(0, 7) == 0)
                issue_both(addr & 16'h1FFF, 8'($urandom_range(0, 255)));
            else
                issue(sel, addr, 8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
        rand_ready = 1'b0;
        ready_level = 1'b1;
        wait_drain();
        check("rand_byte_count", 32'(byte_count), 32'(model_count));
        check("rand_checksum", 32'(checksum), 32'(exp_ck()));
        check("rand_err_flags", 32'(err_flags), 32'(exp_err));
        wait_ready();

        // 5: new edge in READY re-enters LOADING on the next cycle
        model_edge(1'b0, 16'h0042, 8'h5A, 1'b0);
        step();
        rom_addr = 16'h0042;
        rom_data = 8'h5A;
        prg_rom_write = 1'b1;
        @(negedge clk);
        check("t5_pre_nes_reset", 32'(nes_reset), 32'd0);
        @(negedge clk);
        check("t5_nes_reset", 32'(nes_reset), 32'd1);
        check("t5_load_done", 32'(load_done), 32'd0);
        check("t5_byte_count_clr", 32'(byte_count), 32'd0);
        step();
        prg_rom_write = 1'b0;
        wait_drain();

        // 5b: asynchronous reset in the middle of a stalled drain
        ready_level = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++)
            issue(1'b0, 16'(16'h0100 + i), 8'(8'hC0 + i), 1, 1'b1);
        repeat (3) step();
        check("t5_drain_pending", 32'(mem_we), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_err = 3'b000;
        model_idle = 1'b1;
        model_count = 0;
        model_sum = 16'h0000;
        #1;
        check("t5_async_mem_we", 32'(mem_we), 32'd0);
        check("t5_async_bus", 32'({mem_sel, mem_addr, mem_wdata}), 32'd0);
        check("t5_async_nes_reset", 32'(nes_reset), 32'd1);
        check("t5_async_load_done", 32'(load_done), 32'd0);
        check("t5_async_byte_count", 32'(byte_count), 32'd0);
        check("t5_async_err_flags", 32'(err_flags), 32'd0);
        check("t5_async_checksum", 32'(checksum), 32'd0);
        ready_level = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        check("t5_no_leftover_we", 32'(mem_we), 32'd0);

        // 6: checksum of 0xFF + 0x02
        issue(1'b0, 16'h0000, 8'hFF, 1, 1'b0);
        issue(1'b1, 16'h0001, 8'h02, 1, 1'b0);
        wait_drain();
        check("t6_checksum", 32'(checksum), 32'(CK_FF02));
        check("t6_byte_count", 32'(byte_count), 32'd2);
        wait_ready();
        check("t6_checksum_frozen", 32'(checksum), 32'(CK_FF02));
        check("t6_err_flags", 32'(err_flags), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
